seq_mult_unit: RTL and testbench
================================

SEQ_MULT_UNIT -- requirements
Module: seq_mult_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal range 2..64.
REQ-002 SHALL derive localparam PWIDTH = 2*WIDTH, the product width; it is not overridable.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand request.
REQ-006 SHALL have port in_ready  output  1  unit can accept operands.
REQ-007 SHALL have port multiplicand  input  WIDTH  operand A.
REQ-008 SHALL have port multiplier  input  WIDTH  operand B.
REQ-009 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 SHALL have port out_valid  output  1  product available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts product.
REQ-012 SHALL have port product  output  PWIDTH  A*B result.
REQ-013 SHALL have port busy  output  1  high in RUN and DONE states.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE. Transitions: IDLE->RUN on in_valid&in_ready; RUN->DONE after the final step; DONE->IDLE on out_valid&out_ready.
REQ-015 SHALL drive in_ready=1 only in IDLE; no new operation overlaps a pending result.
REQ-016 On the accept edge, SHALL latch multiplicand, multiplier and signed_mode; the accumulator clears to 0 and the step counter to 0. Later input changes are ignored until the next accept.
REQ-017 SHALL perform exactly one shift-add step per RUN cycle, WIDTH steps total. Step rule: if the multiplier LSB is 1, add the multiplicand (sign-extended to WIDTH+1 when signed, zero-extended otherwise) into the WIDTH+1-bit accumulator. Then shift {acc, mq} right by one: arithmetic when signed, logical otherwise.
REQ-018 In signed mode, step WIDTH-1 (multiplier MSB) SHALL subtract instead of add.
REQ-019 SHALL assert out_valid exactly WIDTH clocks after the accept edge, i.e. the edge of step WIDTH.
REQ-020 SHALL set product = {acc[WIDTH-1:0], mq}. Result must be exact for all operand pairs, including unsigned (2^W-1)^2 and signed (-2^(W-1))^2.
REQ-021 SHALL hold product and out_valid stable while out_valid=1 and out_ready=0, for unbounded duration.
REQ-022 If out_ready is already 1 when out_valid rises, SHALL handshake on that same edge and return to IDLE. in_ready rises on the next cycle, so zero-bubble issue is not supported.
REQ-023 SHALL keep product at its last completed value while in IDLE and RUN; out_valid is the only validity qualifier.
REQ-024 in_valid asserted while not in IDLE SHALL have no effect.

Reset
REQ-025 Asserting reset (low) at any time, including mid-RUN or during DONE, SHALL asynchronously force state IDLE, counter 0, accumulator 0, product 0, out_valid 0, busy 0 and in_ready 1. The in-flight operation is discarded.
REQ-026 After reset deasserts, the first accept edge SHALL start a fresh operation with full latency.

Structure
REQ-027 SHALL define a shared package seq_mult_pkg holding the FSM state enum typedef (IDLE, RUN, DONE) and the step-count width helper function.
REQ-028 SHALL instantiate one combinational sub-module, seq_mult_step, that computes a single add/subtract and shift from (acc, mq, mcand, signed_mode, last_step). The counter, FSM and registers stay in seq_mult_unit.
REQ-029 Counter width SHALL be $clog2(WIDTH); it holds no state outside RUN.

Verification (WIDTH=16)
REQ-030 Unsigned case: A=0xFFFF, B=0xFFFF -> product 0xFFFE0001, out_valid exactly 16 clocks after accept.
REQ-031 Signed case: A=0x8000, B=0x8000 -> product 0x40000000. Also A=0xFFFF, B=0x0003 signed -> product 0xFFFFFFFD.
REQ-032 Mode case: A=0x8000, B=0x0002 -> product 0x00010000 when unsigned and 0xFFFF0000 when signed.
REQ-033 Backpressure case: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid and operands -> product, out_valid and in_ready=0 stay unchanged. out_ready=1 -> IDLE on the next edge.
REQ-034 Reset mid-operation: assert reset at step 7 of A=0x1234, B=0x5678 -> all outputs per REQ-025 immediately. Then run A=0x0003, B=0x0005 -> product 0x0000000F after 16 clocks.
REQ-035 Random regression: 10k random operand/mode pairs with random out_ready stalls, checked against a reference model.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding and the step-counter width rule.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // A counter must exist even for the narrowest legal operand width.
    function automatic int step_cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One combinational shift-add iteration of the multiplier datapath.
// Adds or subtracts the multiplicand into acc, then shifts {acc, mq} right by one.
module seq_mult_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   acc_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic [WIDTH-1:0] mcand,
    input  logic             signed_mode,
    input  logic             last_step,
    output logic [WIDTH:0]   acc_out,
    output logic [WIDTH-1:0] mq_out
);

    logic [WIDTH:0] mcand_ext;
    logic [WIDTH:0] sum;
    logic           fill;

    // The multiplier MSB carries negative weight in two's complement, hence the final subtract.
    always_comb begin
        mcand_ext = {signed_mode & mcand[WIDTH-1], mcand};
        sum       = acc_in;
        if (mq_in[0]) begin
            if (signed_mode && last_step) begin
                sum = acc_in - mcand_ext;
            end else begin
                sum = acc_in + mcand_ext;
            end
        end
        fill    = signed_mode & sum[WIDTH];
        acc_out = {fill, sum[WIDTH:1]};
        mq_out  = {sum[0], mq_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_mult_unit.sv
// Sequential WIDTH x WIDTH multiplier, signed or unsigned, one shift-add step per clock.
// Valid/ready on both sides; the result is held in DONE until the consumer takes it.
module seq_mult_unit
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PWIDTH = 2 * WIDTH;
    localparam int CW     = step_cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    mult_state_t      state;
    logic [CW-1:0]    step_cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] mcand;
    logic             mode_signed;

    logic [WIDTH:0]   acc_nxt;
    logic [WIDTH-1:0] mq_nxt;
    logic             last_step;

    assign last_step = (step_cnt == LAST_CNT);

    seq_mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_in      (acc),
        .mq_in       (mq),
        .mcand       (mcand),
        .signed_mode (mode_signed),
        .last_step   (last_step),
        .acc_out     (acc_nxt),
        .mq_out      (mq_nxt)
    );

    // Control and datapath share one block so every output is registered with its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            step_cnt    <= '0;
            acc         <= '0;
            mq          <= '0;
            mcand       <= '0;
            mode_signed <= 1'b0;
            product     <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand       <= multiplicand;
                        mq          <= multiplier;
                        mode_signed <= signed_mode;
                        acc         <= '0;
                        step_cnt    <= '0;
                        state       <= RUN;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    mq  <= mq_nxt;
                    if (last_step) begin
                        step_cnt  <= '0;
                        product   <= PWIDTH'({acc_nxt[WIDTH-1:0], mq_nxt});
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        step_cnt <= step_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    step_cnt  <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_unit.sv
// Directed bench for seq_mult_unit at WIDTH=16 with hand-computed products.
// Covers latency, signed/unsigned corners, backpressure and mid-operation reset.
module tb_seq_mult_unit;

    localparam int WIDTH  = 16;
    localparam int PWIDTH = 2 * WIDTH;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  multiplicand;
    logic [WIDTH-1:0]  multiplier;
    logic              signed_mode;
    logic              out_valid;
    logic              out_ready;
    logic [PWIDTH-1:0] product;
    logic              busy;

    int checks = 0;
    int errors = 0;

    seq_mult_unit #(
        .WIDTH (WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .signed_mode  (signed_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s);
        @(negedge clk);
        checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
        multiplicand = a;
        multiplier   = b;
        signed_mode  = s;
        in_valid     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid     = 1'b0;
        multiplicand = 16'hDEAD;
        multiplier   = 16'hBEEF;
        signed_mode  = ~s;
    endtask

    // Full operation: exact 16-clock latency, held result, optional stall, handshake back to IDLE.
    task automatic runOp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic [PWIDTH-1:0] expected,
                         input logic [PWIDTH-1:0] previous, input int stall);
        applyStimulus(a, b, s);
        checkOutput({tag, "_busy_run"}, 64'(busy), 64'd1);
        checkOutput({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
        checkOutput({tag, "_product_held_run"}, 64'(product), 64'(previous));
        repeat (15) @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_out_valid_early"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_product"}, 64'(product), 64'(expected));
        for (int i = 0; i < stall; i++) begin
            in_valid     = ~in_valid;
            multiplicand = WIDTH'($urandom);
            multiplier   = WIDTH'($urandom);
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_stall_out_valid"}, 64'(out_valid), 64'd1);
            checkOutput({tag, "_stall_product"}, 64'(product), 64'(expected));
            checkOutput({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_out_valid_cleared"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_busy_idle"}, 64'(busy), 64'd0);
        checkOutput({tag, "_product_held_idle"}, 64'(product), 64'(expected));
    endtask

    initial begin
        reset        = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        signed_mode  = 1'b0;
        #12;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_product", 64'(product), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        runOp("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 32'h00000000, 0);
        runOp("s_8000_8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000, 32'hFFFE0001, 0);
        runOp("s_ffff_0003", 16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD, 32'h40000000, 0);
        runOp("u_8000_0002", 16'h8000, 16'h0002, 1'b0, 32'h00010000, 32'hFFFFFFFD, 0);
        runOp("s_8000_0002", 16'h8000, 16'h0002, 1'b1, 32'hFFFF0000, 32'h00010000, 0);
        runOp("s_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 32'hFFFF0000, 0);
        runOp("s_7fff_8000", 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 32'h00000001, 0);
        runOp("u_1234_5678", 16'h1234, 16'h5678, 1'b0, 32'h06260060, 32'hC0008000, 0);
        runOp("bp_00ff_0101", 16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 32'h06260060, 5);

        // Abort an operation part-way through and confirm reset wins immediately.
        applyStimulus(16'h1234, 16'h5678, 1'b0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("midrun_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrun_reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrun_reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
        checkOutput("midrun_reset_product", 64'(product), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        runOp("after_reset_3_5", 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 32'h00000000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
